// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester arbiter and access sequencer for the 1024x32 data RAM
// Optional: define ARB_FIXED_PRIO_EN to give m0 fixed priority instead of round-robin.
module ram_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_size,
  input  logic              m0_signed,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_size,
  input  logic              m1_signed,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_rw,
  output logic [3:0]        ram_sel,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
`ifndef ARB_FIXED_PRIO_EN
  logic        last_q, last_d;
`endif

  logic              any_req, pick, busy;
  logic              r_we, r_sgn;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              legal;
  logic [3:0]        lane_sel;
  logic [DATA_W-1:0] lane_data, ext_data;

  assign any_req = m0_req | m1_req;

  always_comb begin
    pick = m0_req ? 1'b0 : 1'b1;
`ifndef ARB_FIXED_PRIO_EN
    if (m0_req && m1_req) pick = ~last_q;
`endif
  end

  assign r_we    = pick ? m1_we     : m0_we;
  assign r_sgn   = pick ? m1_signed : m0_signed;
  assign r_size  = pick ? m1_size   : m0_size;
  assign r_addr  = pick ? m1_addr   : m0_addr;
  assign r_wdata = pick ? m1_wdata  : m0_wdata;

  // Lane placement of the granted request; size 11 stays illegal by default.
  always_comb begin
    legal     = 1'b0;
    lane_sel  = 4'b0000;
    lane_data = '0;
    case (r_size)
      2'b00: begin
        legal     = 1'b1;
        lane_sel  = 4'b0001 << r_addr[1:0];
        lane_data = {24'd0, r_wdata[7:0]} << {r_addr[1:0], 3'b000};
      end
      2'b01: begin
        legal     = ~r_addr[0];
        lane_sel  = r_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = r_addr[1] ? {r_wdata[15:0], 16'd0} : {16'd0, r_wdata[15:0]};
      end
      2'b10: begin
        legal     = (r_addr[1:0] == 2'b00);
        lane_sel  = 4'b1111;
        lane_data = r_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    err_d       = err_q;
    we_d        = we_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
`ifndef ARB_FIXED_PRIO_EN
    last_d      = last_q;
`endif
    ram_rw      = 1'b0;
    ram_sel     = 4'b0000;
    ram_addr    = '0;
    ram_data_in = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          ram_addr = r_addr[ADDR_W-1:2];
          if (legal) begin
            ram_rw      = r_we;
            ram_sel     = lane_sel;
            ram_data_in = lane_data;
          end
          state_d = BUSY;
          gnt_d   = pick;
          err_d   = ~legal;
          we_d    = r_we;
          size_d  = r_size;
          sgn_d   = r_sgn;
`ifndef ARB_FIXED_PRIO_EN
          last_d  = pick;
`endif
        end
      end
      BUSY: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
`ifndef ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  // RAM returns low-justified zero-extended data, so only signed loads need work.
  always_comb begin
    ext_data = ram_data_out;
    if (sgn_q && size_q == 2'b00) ext_data = {{24{ram_data_out[7]}}, ram_data_out[7:0]};
    else if (sgn_q && size_q == 2'b01) ext_data = {{16{ram_data_out[15]}}, ram_data_out[15:0]};
    if (we_q || err_q) ext_data = '0;
  end

  assign busy     = (state_q == BUSY);
  assign m0_ack   = busy & ~gnt_q;
  assign m0_err   = busy & ~gnt_q & err_q;
  assign m0_rdata = (busy & ~gnt_q) ? ext_data : '0;
  assign m1_ack   = busy & gnt_q;
  assign m1_err   = busy & gnt_q & err_q;
  assign m1_rdata = (busy & gnt_q) ? ext_data : '0;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter with a byte-array reference model
module tb_ram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_signed, m0_ack, m0_err;
  logic [1:0]  m0_size;
  logic [11:0] m0_addr;
  logic [31:0] m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_signed, m1_ack, m1_err;
  logic [1:0]  m1_size;
  logic [11:0] m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic        ram_rw;
  logic [3:0]  ram_sel;
  logic [9:0]  ram_addr;
  logic [31:0] ram_data_in;
  logic [31:0] ram_q = '0;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_signed(m0_signed),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_signed(m1_signed),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .ram_rw(ram_rw), .ram_sel(ram_sel), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_q)
  );

  // Behavioural RAM: byte-lane writes, registered low-justified read of the selected lanes.
  logic [31:0] ram_words [0:1023];
  bit          ram_inited = 1'b0;
  always @(posedge clk) begin : ram_model
    logic [31:0] w, m;
    int lo;
    if (!ram_inited) begin
      for (int i = 0; i < 1024; i++) ram_words[i] <= '0;
      ram_inited <= 1'b1;
    end else if (ram_sel != 4'b0000) begin
      w  = ram_words[ram_addr];
      m  = '0;
      lo = 0;
      for (int i = 3; i >= 0; i--) if (ram_sel[i]) begin m[8*i +: 8] = 8'hFF; lo = i; end
      if (ram_rw) ram_words[ram_addr] <= (w & ~m) | (ram_data_in & m);
      ram_q <= (w & m) >> (8 * lo);
    end
  end

  typedef struct {
    bit        we;
    bit [1:0]  size;
    bit        sgn;
    bit [11:0] addr;
    bit [31:0] wdata;
  } op_t;

  op_t      op [2];
  bit       act [2];
  bit [7:0] mem [0:4095];
  int       last = 1;
  int       checks = 0;
  int       failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    m0_req = act[0]; m0_we = op[0].we; m0_size = op[0].size; m0_signed = op[0].sgn;
    m0_addr = op[0].addr; m0_wdata = op[0].wdata;
    m1_req = act[1]; m1_we = op[1].we; m1_size = op[1].size; m1_signed = op[1].sgn;
    m1_addr = op[1].addr; m1_wdata = op[1].wdata;
  endtask

  // One arbitration slot, entered and left at a negedge while the DUT is idle.
  task automatic slot(input bit keep);
    int g, n, a;
    bit legal;
    op_t o;
    longint v, msk;
    logic [31:0] exp_r;
    if (act[0] && act[1]) begin
`ifdef ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = (last == 0) ? 1 : 0;
`endif
    end else begin
      g = act[0] ? 0 : 1;
    end
    last  = g;
    o     = op[g];
    n     = 1 << o.size;
    a     = o.addr % 4;
    legal = (o.size != 2'd3) && (o.addr % n == 0);
    msk   = (64'd1 << (8 * n)) - 1;
    apply();
    #1;
    chk("issue_addr", 32'(ram_addr), 32'(o.addr / 4));
    chk("issue_rw", 32'(ram_rw), 32'(legal && o.we));
    chk("issue_sel", 32'(ram_sel), legal ? 32'(((1 << n) - 1) << a) : 32'd0);
    if (legal && o.we)
      chk("issue_din", ram_data_in, 32'((longint'(o.wdata) & msk) << (8 * a)));
    exp_r = '0;
    if (legal && !o.we) begin
      v = 0;
      for (int i = 0; i < n; i++) v |= longint'(mem[o.addr + i]) << (8 * i);
      if (o.sgn && n < 4 && v[8*n-1]) v |= ~msk;
      exp_r = v[31:0];
    end
    if (legal && o.we)
      for (int i = 0; i < n; i++) mem[o.addr + i] = o.wdata[8*i +: 8];
    @(negedge clk);
    #1;
    chk("ack_granted", 32'(g ? m1_ack : m0_ack), 32'd1);
    chk("ack_other", 32'(g ? m0_ack : m1_ack), 32'd0);
    chk("err", 32'(g ? m1_err : m0_err), 32'(!legal));
    chk("err_other", 32'(g ? m0_err : m1_err), 32'd0);
    chk("rdata", g ? m1_rdata : m0_rdata, exp_r);
    chk("rdata_other", g ? m0_rdata : m1_rdata, 32'd0);
    act[g] = keep;
    apply();
    @(negedge clk);
  endtask

  task automatic single(input int p, input bit we, input bit [1:0] size, input bit sgn,
                        input bit [11:0] addr, input bit [31:0] wdata);
    op[p].we = we; op[p].size = size; op[p].sgn = sgn; op[p].addr = addr; op[p].wdata = wdata;
    act[p] = 1'b1;
    slot(1'b0);
  endtask

  initial begin
    act[0] = 1'b0; act[1] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      op[p].we = 1'b0; op[p].size = 2'd0; op[p].sgn = 1'b0; op[p].addr = '0; op[p].wdata = '0;
    end
    apply();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_m0_ack", 32'(m0_ack), 32'd0);
    chk("rst_m1_ack", 32'(m1_ack), 32'd0);
    chk("rst_m0_err", 32'(m0_err), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_ram_rw", 32'(ram_rw), 32'd0);
    chk("rst_ram_sel", 32'(ram_sel), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    single(0, 1, 2'd2, 0, 12'h010, 32'hDEADBEEF);
    single(0, 0, 2'd2, 0, 12'h010, 32'h0);
    single(0, 1, 2'd0, 0, 12'h013, 32'h00000080);
    single(0, 0, 2'd0, 1, 12'h013, 32'h0);
    single(1, 0, 2'd0, 0, 12'h013, 32'h0);
    single(0, 1, 2'd1, 0, 12'h012, 32'h00008001);
    single(0, 0, 2'd1, 1, 12'h012, 32'h0);
    single(1, 1, 2'd2, 0, 12'h000, 32'h12345678);
    single(1, 1, 2'd2, 0, 12'h002, 32'hAAAAAAAA);
    single(0, 1, 2'd1, 0, 12'h001, 32'hBBBBBBBB);
    single(0, 0, 2'd3, 1, 12'h000, 32'h0);
    single(1, 0, 2'd2, 0, 12'h000, 32'h0);

    // Reset landing in the ack cycle drops the access.
    op[0].we = 1'b0; op[0].size = 2'd2; op[0].sgn = 1'b0; op[0].addr = 12'h010;
    act[0] = 1'b1; act[1] = 1'b0;
    apply();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rstbusy_ack", 32'(m0_ack), 32'd0);
    chk("rstbusy_rdata", m0_rdata, 32'd0);
    act[0] = 1'b0;
    apply();
    @(negedge clk);
    rst = 1'b0;
    last = 1;
    @(negedge clk);
    op[0].we = 1'b0; op[0].size = 2'd2; op[0].sgn = 1'b0; op[0].addr = 12'h010;
    op[1].we = 1'b0; op[1].size = 2'd1; op[1].sgn = 1'b1; op[1].addr = 12'h012;
    act[0] = 1'b1; act[1] = 1'b1;
    slot(1'b0);
    while (act[0] || act[1]) slot(1'b0);

    // Sustained contention: both requests held across four accesses.
    act[0] = 1'b1; act[1] = 1'b1;
    for (int k = 0; k < 4; k++) slot(1'b1);
    act[0] = 1'b0; act[1] = 1'b0;
    apply();
    @(negedge clk);

    for (int k = 0; k < 80; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && ($urandom % 3 != 0)) begin
          op[p].we    = 1'($urandom % 2);
          op[p].size  = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
          op[p].sgn   = 1'($urandom % 2);
          op[p].addr  = ($urandom % 2 == 0) ? 12'($urandom_range(0, 31)) : 12'($urandom_range(4064, 4095));
          op[p].wdata = $urandom;
          act[p]      = 1'b1;
        end
      end
      if (!act[0] && !act[1]) act[0] = 1'b1;
      slot(1'b0);
    end
    while (act[0] || act[1]) slot(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Two-requester arbiter and access sequencer in front of the single-port data RAM (1024 x 32, byte-lane select, registered read data).
- Requester 0 is the MEM stage; requester 1 is the debug/loader port.
- Converts byte address plus access size into word address, lane select and lane-shifted store data.
- Sign- or zero-extends load data and reports misaligned accesses without touching the RAM.

Parameters:
ADDR_W, 12, byte address width; RAM word address is ADDR_W-2 = 10 bits
DATA_W, 32, data width (fixed at 32; lane logic assumes 4 byte lanes)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
m0_req  in  1  request from requester 0; held stable until m0_ack
m0_we  in  1  1 = store, 0 = load
m0_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
m0_signed  in  1  load sign-extends when 1
m0_addr  in  12  byte address
m0_wdata  in  32  store data, right-justified
m0_ack  out  1  one-cycle completion pulse
m0_err  out  1  valid with m0_ack; misaligned or illegal size
m0_rdata  out  32  load data, valid with m0_ack
m1_*  same set as m0_*, for requester 1
ram_rw  out  1  RAM write enable
ram_sel  out  4  RAM byte-lane select
ram_addr  out  10  RAM word address
ram_data_in  out  32  RAM write data
ram_data_out  in  32  RAM read data; registered in RAM, low-justified, zero-extended

Behaviour:
Reset
- rst asynchronously forces state IDLE, ack/err 0, rdata 0, last_grant = 1 (so m0 wins the first tie).
- Reset mid-access drops the access with no ack. A write whose issue edge coincides with reset is not guaranteed.

FSM states
- IDLE:
  - If no request: ram_rw = 0, ram_sel = 0, ram_addr = 0, ram_data_in = 0.
  - If any request: grant one requester. The issue cycle is this IDLE cycle; ram_* are driven combinationally from the granted requester. Go to BUSY and register the grant id and the err flag.
- BUSY (exactly one cycle):
  - ram_rw = 0, ram_sel = 0.
  - Pulse ack for the granted requester; err = registered flag; rdata = extended ram_data_out (0 for stores or err).
  - Next state IDLE.
- Result: latency is request-to-ack 1 cycle (ack in the cycle after issue); peak throughput is 1 access per 2 cycles.

Arbitration
- Only one requester: it is granted.
- Both requesting: round-robin; grant the one not in last_grant, then update last_grant.
- Requests are sampled only in IDLE. A req deassert during BUSY is ignored; the ack still pulses.

Address and lane rules (a = addr[1:0])
- ram_addr = addr[11:2].
- byte: sel = 1 << a; data_in = wdata[7:0] << 8*a.
- half: a[0] must be 0; sel = a[1] ? 1100 : 0011; data_in = wdata[15:0] << 16*a[1].
- word: a must be 00; sel = 1111; data_in = wdata.
- Misaligned access or size 11: err; ram_rw = 0 and ram_sel = 0 in the issue cycle, so no RAM side effect.
- ram_rw = we only on a legal issue cycle.

Load extension
- byte with signed: replicate bit 7 into [31:8].
- half with signed: replicate bit 15 into [31:16].
- Otherwise pass ram_data_out unchanged (already zero-extended).

Outputs of the requester not granted stay 0.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: fixed priority; m0 always wins simultaneous requests; last_grant is unused.
- Undefined: round-robin as above.

Test Plan:
- Word store then load, m0: store addr 0x010, wdata 0xDEADBEEF; load word 0x010 -> ram_rw = 1, sel = 1111, ram_addr = 4 on issue; ack next cycle; rdata = 0xDEADBEEF, err = 0.
- Byte sign extension: store byte 0x80 at 0x013 (sel = 1000, data_in = 0x80000000); signed load byte 0x013 -> rdata 0xFFFFFF80; unsigned load -> 0x00000080.
- Half sign extension: signed load half at 0x012 holding 0x8001 -> sel = 1100, rdata 0xFFFF8001.
- Round-robin contention: m0 and m1 both hold req for 4 accesses -> grants m0, m1, m0, m1; acks 2 cycles apart. With ARB_FIXED_PRIO_EN, m0 is granted every time while it keeps requesting.
- Misalignment: word access at 0x002; half at 0x001; size 11 -> ack with err = 1, rdata 0, ram_rw = 0 and ram_sel = 0; the RAM word is unchanged on re-read.
- Reset during BUSY: assert rst in the ack cycle -> ack forced to 0 immediately; state IDLE; the next tie grants m0.
